// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronizes two active-low keys and an 8-bit switch bank,
// debounces each key with its own FSM, and emits one-cycle press strobes.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] key_n,
    input  logic [7:0] sw,
    output logic       start_pulse,
    output logic       load_pulse,
    output logic [7:0] sw_value,
    output logic [1:0] key_held
);

    localparam int unsigned CW = 21;
    localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } key_state_t;

    logic [1:0] key_s1, key_s2;
    logic [7:0] sw_s1, sw_s2;
    logic [1:0] pressed;
    logic [1:0] fire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    assign pressed = ~key_s2;

    for (genvar g = 0; g < 2; g++) begin : g_key
        key_state_t    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          fire_d;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q <= ARM;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Transitions fire on the sample that would bring the count to FULL,
        // so the counter never has to hold more than FULL.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            fire_d  = 1'b0;
            case (state_q)
                ARM: begin
                    if (pressed[g]) begin
                        cnt_d = '0;
                    end else if (cnt_q >= LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                IDLE: begin
                    if (pressed[g]) begin
                        state_d = PRESS;
                        cnt_d   = CW'(1);
                    end
                end
                PRESS: begin
                    if (!pressed[g]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= LAST) begin
                        state_d = HELD;
                        cnt_d   = FULL;
                        fire_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!pressed[g]) begin
                        state_d = RELEASE;
                        cnt_d   = CW'(1);
                    end
                end
                RELEASE: begin
                    if (pressed[g]) begin
                        state_d = HELD;
                        cnt_d   = FULL;
                    end else if (cnt_q >= LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            endcase
        end

        assign fire[g]     = fire_d;
        assign key_held[g] = (state_q == HELD) || (state_q == RELEASE);
    end

    // Start wins a simultaneous press; the suppressed load also skips the capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_pulse <= 1'b0;
            load_pulse  <= 1'b0;
            sw_value    <= '0;
        end else begin
            start_pulse <= fire[0];
            load_pulse  <= fire[1] & ~fire[0];
            if (fire[1] && !fire[0]) begin
                sw_value <= sw_s2;
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios followed by random key
// activity, compared every cycle against a level/run-length reference model.
module tb_key_conditioner;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] key_n;
    logic [7:0] sw;
    logic       start_pulse, load_pulse;
    logic [7:0] sw_value;
    logic [1:0] key_held;

    int total = 0;
    int bad = 0;

    key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .sw         (sw),
        .start_pulse(start_pulse),
        .load_pulse (load_pulse),
        .sw_value   (sw_value),
        .key_held   (key_held)
    );

    always #5 clock = ~clock;

    // Reference model: each key has an accepted level (1 = pressed) and a run of
    // consecutive samples disagreeing with it; D such samples flip the level.
    // Keys start "pressed but not armed", so only a released-then-pressed key pulses.
    logic [1:0] m_k1, m_k2;
    logic [7:0] m_s1, m_s2;
    logic [1:0] m_level, m_armed;
    int         m_run [2];
    logic       exp_start, exp_load;
    logic [7:0] exp_sw;
    logic [1:0] exp_held;

    int step_no = 0;
    int n_start = 0, n_load = 0;
    int last_start = 0, last_load = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s step=%0d got=%0h exp=%0h", tag, step_no, got, exp);
        end
    endtask

    task automatic model_reset();
        m_k1 = 2'b11; m_k2 = 2'b11; m_s1 = 8'h00; m_s2 = 8'h00;
        m_level = 2'b11; m_armed = 2'b00; m_run[0] = 0; m_run[1] = 0;
        exp_start = 1'b0; exp_load = 1'b0; exp_sw = 8'h00; exp_held = 2'b00;
    endtask

    task automatic model_edge();
        logic [1:0] smp;
        logic [1:0] fire;
        smp  = ~m_k2;
        fire = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (smp[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_level[i] = smp[i];
                    m_run[i]   = 0;
                    if (smp[i]) fire[i] = m_armed[i];
                    else        m_armed[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        exp_start = fire[0];
        exp_load  = fire[1] & ~fire[0];
        if (exp_load) exp_sw = m_s2;
        exp_held = m_level & m_armed;
        m_k2 = m_k1; m_k1 = key_n;
        m_s2 = m_s1; m_s1 = sw;
    endtask

    task automatic step();
        if (reset) model_reset();
        else       model_edge();
        @(posedge clock);
        #1;
        step_no++;
        check("start_pulse", {7'b0, start_pulse}, {7'b0, exp_start});
        check("load_pulse", {7'b0, load_pulse}, {7'b0, exp_load});
        check("sw_value", sw_value, exp_sw);
        check("key_held", {6'b0, key_held}, {6'b0, exp_held});
        if (start_pulse) begin n_start++; last_start = step_no; end
        if (load_pulse)  begin n_load++;  last_load  = step_no; end
    endtask

    int base, s0, l0, held5, held6;
    int run_left [2];

    initial begin
        reset = 1'b1; key_n = 2'b11; sw = 8'h00;
        model_reset();
        #1;
        check("rst_start", {7'b0, start_pulse}, 8'h00);
        check("rst_load", {7'b0, load_pulse}, 8'h00);
        check("rst_sw", sw_value, 8'h00);
        check("rst_held", {6'b0, key_held}, 8'h00);
        repeat (3) step();
        reset = 1'b0;

        // load press after arming: pulse on the 6th edge, switch captured
        repeat (6) step();
        sw = 8'h5A; key_n[1] = 1'b0;
        base = step_no; l0 = n_load;
        repeat (8) step();
        check("r030_count", 8'(n_load - l0), 8'd1);
        check("r030_edge", 8'(last_load - base), 8'(D + 2));
        check("r030_sw", sw_value, 8'h5A);
        check("r030_held1", {7'b0, key_held[1]}, 8'h01);

        // short bounce on start, then a clean press
        s0 = n_start;
        key_n[0] = 1'b0; repeat (3) step();
        key_n[0] = 1'b1; step();
        key_n[0] = 1'b0;
        base = step_no;
        repeat (10) step();
        check("r031_count", 8'(n_start - s0), 8'd1);
        check("r031_edge", 8'(last_start - base), 8'(D + 2));

        // simultaneous presses: start only, switch capture suppressed
        key_n = 2'b11; repeat (10) step();
        sw = 8'hFF; key_n = 2'b00;
        s0 = n_start; l0 = n_load;
        repeat (8) step();
        check("r032_start", 8'(n_start - s0), 8'd1);
        check("r032_load", 8'(n_load - l0), 8'd0);
        check("r032_sw", sw_value, 8'h5A);
        check("r032_held", {6'b0, key_held}, 8'h03);

        // start held through reset release
        key_n = 2'b10; reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        s0 = n_start;
        repeat (20) step();
        check("r033_nopulse", 8'(n_start - s0), 8'd0);
        key_n = 2'b11; repeat (5) step();
        key_n = 2'b10; repeat (8) step();
        check("r033_pulse", 8'(n_start - s0), 8'd1);

        // reset two cycles into PRESS
        key_n = 2'b11; repeat (8) step();
        key_n = 2'b10; repeat (4) step();
        #2 reset = 1'b1;
        #1;
        check("r034_start", {7'b0, start_pulse}, 8'h00);
        check("r034_load", {7'b0, load_pulse}, 8'h00);
        check("r034_sw", sw_value, 8'h00);
        check("r034_held", {6'b0, key_held}, 8'h00);
        model_reset();
        s0 = n_start;
        repeat (3) step();
        key_n = 2'b11; reset = 1'b0;
        repeat (12) step();
        check("r034_nopulse", 8'(n_start - s0), 8'd0);

        // long hold then release with a bounce
        s0 = n_start;
        key_n = 2'b10; repeat (100) step();
        key_n = 2'b11; step();
        key_n = 2'b10; repeat (2) step();
        key_n = 2'b11;
        held5 = 0; held6 = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == D + 1) held5 = int'(key_held[0]);
            if (k == D + 2) held6 = int'(key_held[0]);
        end
        check("r035_count", 8'(n_start - s0), 8'd1);
        check("r035_held_before", 8'(held5), 8'd1);
        check("r035_held_after", 8'(held6), 8'd0);

        // random key activity with occasional resets
        run_left[0] = 0; run_left[1] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (run_left[i] == 0) begin
                    key_n[i]    = 1'($urandom_range(0, 1));
                    run_left[i] = int'($urandom_range(1, 8));
                end
                run_left[i]--;
            end
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; key_n = 2'b11;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
